// File: rtl/prog_loader.sv
// prog_loader: packs a framed byte stream into 32-bit words, writes them to program memory, verifies a checksum, and gates CPU reset
// Ports:
//   CLK, RST          rising-edge clock, synchronous active-high reset
//   START             begin a new load (honoured in IDLE, DONE, ERROR)
//   IN_DATA/IN_VALID  stream byte and its valid; IN_READY is the registered accept
//   PROG_WE/ADDR/WDATA program memory write port, one strobe per word
//   CPU_HOLD          holds the CPU in reset until a clean load completes
//   DONE, ERR         load completed with matching checksum / load failed
module prog_loader #(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [7:0]        IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic              PROG_WE,
    output logic [ADDR_W-1:0] PROG_ADDR,
    output logic [31:0]       PROG_WDATA,
    output logic              CPU_HOLD,
    output logic              DONE,
    output logic              ERR
);
    // one extra bit so a full-depth count and the final index never wrap
    localparam int CW = ADDR_W + 1;
    localparam int BW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_COUNT, ST_BYTE, ST_WRITE, ST_CHECK, ST_DONE, ST_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, widx_q, widx_d;
    logic [BW-1:0]     bidx_q, bidx_d;
    logic [7:0]        sum_q, sum_d;
    logic [31:0]       word_q, word_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q, ready_d, we_q, we_d;
    logic              hold_q, hold_d, done_q, done_d, err_q, err_d;
    logic              xfer;

    assign xfer       = IN_VALID && ready_q;
    assign IN_READY   = ready_q;
    assign PROG_WE    = we_q;
    assign PROG_ADDR  = addr_q;
    assign PROG_WDATA = wdata_q;
    assign CPU_HOLD   = hold_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        sum_d   = sum_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (START) begin
                state_d = ST_COUNT;
                sum_d   = '0;
                bidx_d  = '0;
                widx_d  = '0;
            end
            ST_COUNT: if (xfer) begin
                state_d = (IN_DATA == 8'd0 || {24'd0, IN_DATA} > 32'(DEPTH)) ? ST_ERROR : ST_BYTE;
                cnt_d   = CW'(IN_DATA);
            end
            ST_BYTE: if (xfer) begin
                word_d = {word_q[23:0], IN_DATA};
                sum_d  = sum_q + IN_DATA;
                bidx_d = bidx_q + BW'(1);
                if (bidx_q == BW'(WORD_BYTES - 1)) begin
                    state_d = ST_WRITE;
                    bidx_d  = '0;
                    we_d    = 1'b1;
                    addr_d  = widx_q[ADDR_W-1:0];
                    wdata_d = {word_q[23:0], IN_DATA};
                end
            end
            ST_WRITE: begin
                widx_d  = widx_q + CW'(1);
                state_d = (widx_q + CW'(1) == cnt_q) ? ST_CHECK : ST_BYTE;
            end
            ST_CHECK: if (xfer) state_d = (IN_DATA == sum_q) ? ST_DONE : ST_ERROR;
            default: state_d = ST_IDLE;
        endcase
        // status outputs are registered copies of the next-state decode
        ready_d = state_d == ST_COUNT || state_d == ST_BYTE || state_d == ST_CHECK;
        hold_d  = state_d != ST_DONE;
        done_d  = state_d == ST_DONE;
        err_d   = state_d == ST_ERROR;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            sum_q   <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            sum_q   <= sum_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frames checked against a frame-level model of the loader
module tb_prog_loader;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [7:0]  IN_DATA = 8'd0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY, PROG_WE, CPU_HOLD, DONE, ERR;
    logic [4:0]  PROG_ADDR;
    logic [31:0] PROG_WDATA;

    int errors = 0;
    int checks = 0;
    logic [4:0]  wa[$];
    logic [31:0] wd[$];
    logic [7:0]  frm[$];

    prog_loader dut (
        .CLK(CLK), .RST(RST), .START(START), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR), .PROG_WDATA(PROG_WDATA),
        .CPU_HOLD(CPU_HOLD), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) if (!RST && PROG_WE) begin
        wa.push_back(PROG_ADDR);
        wd.push_back(PROG_WDATA);
        chk("ready_in_write", 32'(IN_READY), 0);
    end

    task automatic check_reset_vals();
        chk("rst_ready", 32'(IN_READY), 0);
        chk("rst_we", 32'(PROG_WE), 0);
        chk("rst_addr", 32'(PROG_ADDR), 0);
        chk("rst_wdata", PROG_WDATA, 0);
        chk("rst_hold", 32'(CPU_HOLD), 1);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_err", 32'(ERR), 0);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("start_ready", 32'(IN_READY), 1);
        chk("start_done", 32'(DONE), 0);
        chk("start_err", 32'(ERR), 0);
        chk("start_hold", 32'(CPU_HOLD), 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        IN_VALID = 1'b1;
        IN_DATA  = b;
        while (!IN_READY && t < 300) begin
            @(negedge CLK);
            t++;
        end
        if (!IN_READY) chk("ready_timeout", 0, 1);
        @(negedge CLK);
        IN_VALID = 1'b0;
        IN_DATA  = 8'($urandom);
    endtask

    task automatic make_frame(input int n, input bit corrupt);
        logic [7:0] s = 8'd0;
        frm = {};
        frm.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            frm.push_back(8'($urandom));
            s += frm[i+1];
        end
        frm.push_back(corrupt ? s + 8'd1 : s);
    endtask

    // model: a legal count yields N big-endian words at addresses 0..N-1,
    // DONE only when the trailing byte equals the mod-256 data sum
    task automatic run_frame(input int gap, input bit inj);
        int n = int'(frm[0]);
        bit ok = n >= 1 && n <= 32;
        int nb = ok ? 4 * n + 2 : 1;
        int t = 0;
        logic [7:0] s = 8'd0;
        bit exp_done;
        wa = {};
        wd = {};
        pulse_start();
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, gap)) @(negedge CLK);
            if (inj && i == 3) begin
                START = 1'b1;
                @(negedge CLK);
                START = 1'b0;
            end
            send_byte(frm[i]);
        end
        while (!(DONE || ERR) && t < 20) begin
            @(negedge CLK);
            t++;
        end
        for (int i = 0; ok && i < 4 * n; i++) s += frm[i+1];
        exp_done = ok && s == frm[4*n+1];
        chk("done", 32'(DONE), 32'(exp_done));
        chk("err", 32'(ERR), 32'(!exp_done));
        chk("hold", 32'(CPU_HOLD), 32'(!exp_done));
        chk("nwrites", wa.size(), ok ? n : 0);
        for (int i = 0; ok && i < n && i < wa.size(); i++) begin
            chk("waddr", 32'(wa[i]), i);
            chk("wdata", wd[i], {frm[4*i+1], frm[4*i+2], frm[4*i+3], frm[4*i+4]});
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check_reset_vals();
        RST = 1'b0;
        @(negedge CLK);
        frm = {8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
        run_frame(0, 1'b0);
        frm = {8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        run_frame(0, 1'b0);
        frm[9] = 8'h65;
        run_frame(1, 1'b0);
        frm = {8'h00};
        run_frame(0, 1'b0);
        frm = {8'h21};
        run_frame(0, 1'b0);
        frm = {8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
        run_frame(3, 1'b1);
        wa = {};
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_vals();
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        chk("aborted_writes", wa.size(), 0);
        make_frame(1, 1'b0);
        run_frame(2, 1'b0);
        make_frame(32, 1'b0);
        run_frame(1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            make_frame($urandom_range(1, 32), 1'($urandom));
            run_frame($urandom_range(0, 2), 1'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
